// File: rtl/fifo_write_arbiter_if.sv
// Producer handshake and FIFO write-port bundle shared by the round-robin write arbiter.
// The arbiter connects through the slave modport; producers and the FIFO sit on the master side.
interface fifo_write_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 4
) ();
    localparam int GID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   fifo_full;
    logic                   fifo_write;
    logic [WIDTH-1:0]       fifo_data_in;
    logic                   grant_valid;
    logic [GID_W-1:0]       grant_id;

    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_write, fifo_data_in, grant_valid, grant_id
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_write, fifo_data_in, grant_valid, grant_id
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers,
// with bursts of up to MAX_BURST words per grant and back-pressure from the FIFO full flag.
//
// state | meaning
// IDLE  | no owner; search for a requester, grant takes effect next cycle
// BURST | grant_id owns the port; words pass straight through when not full
module fifo_write_arbiter #(
    parameter int WIDTH     = 32,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    fifo_write_arbiter_if.slave bus
);
    localparam int GID_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [GID_W-1:0] idx;
    } arb_t;

    state_t           state_q, state_d;
    logic [GID_W-1:0] grant_id_q, grant_id_d;
    logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic xfer;
    logic burst_last;
    logic burst_done;
    arb_t arb;

    function automatic logic [GID_W-1:0] wrap_inc(input logic [GID_W-1:0] v);
        if (int'(v) == N_REQ - 1) begin
            return '0;
        end
        return v + GID_W'(1);
    endfunction

    // First set valid bit at or after start, wrapping modulo N_REQ.
    function automatic arb_t rr_search(input logic [N_REQ-1:0] valid,
                                       input logic [GID_W-1:0] start);
        arb_t             r;
        logic [GID_W-1:0] idx;
        r   = '0;
        idx = start;
        for (int k = 0; k < N_REQ; k++) begin
            if (!r.found && valid[idx]) begin
                r.found = 1'b1;
                r.idx   = idx;
            end
            idx = wrap_inc(idx);
        end
        return r;
    endfunction

    assign burst_last = (burst_cnt_q == CNT_W'(MAX_BURST - 1));

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        xfer        = 1'b0;
        burst_done  = 1'b0;
        arb         = '0;

        case (state_q)
            IDLE: begin
                arb = rr_search(bus.req_valid, rr_ptr_q);
                if (arb.found) begin
                    state_d     = BURST;
                    grant_id_d  = arb.idx;
                    burst_cnt_d = '0;
                end
            end

            BURST: begin
                xfer = bus.req_valid[grant_id_q] && !bus.fifo_full;
                if (xfer) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
                burst_done = (xfer && burst_last) || !bus.req_valid[grant_id_q];
                // Re-arbitrate from the slot after the owner so it is lowest priority.
                if (burst_done) begin
                    rr_ptr_d    = wrap_inc(grant_id_q);
                    arb         = rr_search(bus.req_valid, rr_ptr_d);
                    burst_cnt_d = '0;
                    if (arb.found) begin
                        grant_id_d = arb.idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.req_ready    = '0;
        bus.fifo_write   = 1'b0;
        bus.fifo_data_in = '0;
        bus.grant_valid  = (state_q == BURST);
        bus.grant_id     = grant_id_q;
        if (state_q == BURST) begin
            bus.req_ready[grant_id_q] = !bus.fifo_full;
            bus.fifo_write            = xfer;
            bus.fifo_data_in          = bus.req_data[grant_id_q*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus random traffic against a
// word-level reference model, per-producer ordering scoreboard and fairness tracking.
module tb_fifo_write_arbiter;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.WIDTH(W), .N_REQ(N)) bus ();

    fifo_write_arbiter #(.WIDTH(W), .N_REQ(N), .MAX_BURST(MB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // producers: words still to send and sequence number of the presented word
    int         words_left[N];
    int         seq[N];
    int         rx_seq[N];
    logic [N-1:0] pv;
    logic       full;

    // reference model: owner, words taken in this grant, search start
    bit   m_busy;
    int   m_gid, m_ptr, m_cnt;
    logic [N-1:0] e_ready;
    logic         e_write;
    logic [W-1:0] e_data;

    int wait_cnt[N];
    int grant_log[$];
    int wr_total, first_wr, last_wr, cyc;
    logic obs_gv, obs_wr;
    logic [N-1:0] obs_ready;
    int obs_gid;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] word_of(input int i);
        return {8'(i), 24'(seq[i])};
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            pv[i] = (words_left[i] > 0);
            bus.req_data[i*W +: W] = word_of(i);
        end
        bus.req_valid = pv;
        bus.fifo_full = full;
    endtask

    task automatic model_reset();
        m_busy = 0; m_gid = 0; m_ptr = 0; m_cnt = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    endtask

    task automatic clear_log();
        grant_log.delete();
        wr_total = 0; first_wr = -1; last_wr = -1;
    endtask

    task automatic cycle();
        int p, taken, nb, ng, np, nc, new_grant;
        drive();
        @(negedge clk);
        e_ready = '0; e_write = 1'b0; e_data = '0;
        nb = m_busy; ng = m_gid; np = m_ptr; nc = m_cnt; new_grant = -1;
        if (!m_busy) begin
            p = pick(pv, m_ptr);
            if (p >= 0) begin nb = 1; ng = p; nc = 0; new_grant = p; end
        end else begin
            if (!full) e_ready[m_gid] = 1'b1;
            e_write = pv[m_gid] && !full;
            e_data  = word_of(m_gid);
            taken   = m_cnt + (e_write ? 1 : 0);
            nc      = taken;
            if ((e_write && taken == MB) || !pv[m_gid]) begin
                np = (m_gid + 1) % N;
                nc = 0;
                p  = pick(pv, np);
                if (p >= 0) begin ng = p; new_grant = p; end
                else nb = 0;
            end
        end
        check_eq("grant_valid", bus.grant_valid, m_busy);
        check_eq("grant_id", bus.grant_id, m_gid);
        check_eq("req_ready", bus.req_ready, e_ready);
        check_eq("fifo_write", bus.fifo_write, e_write);
        check_eq("fifo_data_in", bus.fifo_data_in, e_data);
        obs_gv = bus.grant_valid; obs_wr = bus.fifo_write;
        obs_ready = bus.req_ready; obs_gid = int'(bus.grant_id);
        if (bus.fifo_write) begin
            wr_total++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            check_eq("write_while_full", bus.fifo_full, 1'b0);
            p = int'(bus.fifo_data_in[31:24]);
            check_eq("word_src", p < N, 1'b1);
            if (p < N) begin
                check_eq("word_order", bus.fifo_data_in[23:0], rx_seq[p]);
                rx_seq[p]++;
            end
        end
        if (new_grant >= 0) begin
            grant_log.push_back(new_grant);
            check_eq("fair_wait", wait_cnt[new_grant] <= N - 1, 1'b1);
            wait_cnt[new_grant] = 0;
            for (int i = 0; i < N; i++) if (i != new_grant && pv[i]) wait_cnt[i]++;
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (e_ready[i] && pv[i]) begin
                words_left[i]--;
                seq[i]++;
            end
        end
        m_busy = (nb != 0); m_gid = ng; m_ptr = np; m_cnt = nc;
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        drive();
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    int nfull;
    int exp_t1[5] = '{0, 1, 2, 3, 0};
    bit busy_any;

    initial begin
        cyc = 0; full = 1'b0; reset_n = 1'b0;
        for (int i = 0; i < N; i++) begin seq[i] = 0; rx_seq[i] = 0; end
        words_left = '{8, 4, 4, 4};
        model_reset();
        clear_log();
        drive();

        // 1: all valid out of reset
        @(negedge clk);
        check_eq("rst_grant_valid", bus.grant_valid, 1'b0);
        check_eq("rst_fifo_write", bus.fifo_write, 1'b0);
        check_eq("rst_req_ready", bus.req_ready, '0);
        check_eq("rst_data", bus.fifo_data_in, '0);
        check_eq("rst_grant_id", bus.grant_id, '0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int c = 0; c < 26; c++) cycle();
        check_eq("t1_writes", wr_total, 20);
        check_eq("t1_span", last_wr - first_wr + 1, 20);
        check_eq("t1_ngrants", grant_log.size() >= 5, 1'b1);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            check_eq("t1_grant_order", grant_log[k], exp_t1[k]);

        // 2: lone producer 2, 10 words as bursts 4,4,2
        clear_log();
        words_left[2] = 10;
        for (int c = 0; c < 16; c++) cycle();
        check_eq("t2_writes", wr_total, 10);
        check_eq("t2_span", last_wr - first_wr + 1, 10);
        check_eq("t2_ngrants", grant_log.size(), 3);
        foreach (grant_log[k]) check_eq("t2_grant_id", grant_log[k], 2);
        check_eq("t2_idle", obs_gv, 1'b0);

        // 3: full for 5 cycles after producer 1's 2nd word
        clear_log();
        words_left[1] = 6;
        nfull = 0;
        for (int c = 0; c < 18; c++) begin
            if (wr_total >= 2 && nfull < 5) begin full = 1'b1; nfull++; end
            else full = 1'b0;
            cycle();
            if (full) begin
                check_eq("t3_full_write", obs_wr, 1'b0);
                check_eq("t3_full_ready", obs_ready, '0);
                check_eq("t3_full_gv", obs_gv, 1'b1);
                check_eq("t3_full_gid", obs_gid, 1);
            end
        end
        full = 1'b0;
        check_eq("t3_writes", wr_total, 6);
        check_eq("t3_ngrants", grant_log.size(), 2);

        // 4: producer 0 drops after one word, grant moves to 3 with no bubble
        do_reset();
        clear_log();
        words_left[0] = 1; words_left[3] = 2;
        cycle(); cycle(); cycle();
        check_eq("t4_exit_gv", obs_gv, 1'b1);
        check_eq("t4_exit_gid", obs_gid, 0);
        check_eq("t4_exit_wr", obs_wr, 1'b0);
        cycle();
        check_eq("t4_next_gv", obs_gv, 1'b1);
        check_eq("t4_next_gid", obs_gid, 3);
        check_eq("t4_next_wr", obs_wr, 1'b1);
        for (int c = 0; c < 4; c++) cycle();

        // 5: reset mid-burst after producer 2's 2nd word
        do_reset();
        clear_log();
        words_left[2] = 4;
        for (int c = 0; c < 10 && wr_total < 2; c++) cycle();
        check_eq("t5_two_words", wr_total, 2);
        reset_n = 1'b0;
        #1;
        check_eq("t5_rst_write", bus.fifo_write, 1'b0);
        check_eq("t5_rst_ready", bus.req_ready, '0);
        check_eq("t5_rst_gv", bus.grant_valid, 1'b0);
        model_reset();
        words_left[0] = 1; words_left[1] = 1; words_left[3] = 1;
        @(posedge clk);
        #1 reset_n = 1'b1;
        clear_log();
        for (int c = 0; c < 20; c++) cycle();
        check_eq("t5_ngrants", grant_log.size() >= 1, 1'b1);
        if (grant_log.size() >= 1) check_eq("t5_first_grant", grant_log[0], 0);

        // 6: random valid/full traffic
        for (int c = 0; c < 10000; c++) begin
            full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++)
                if (words_left[i] == 0 && $urandom_range(0, 3) == 0)
                    words_left[i] = $urandom_range(1, 10);
            cycle();
        end
        full = 1'b0;
        busy_any = 1'b1;
        for (int c = 0; c < 300 && busy_any; c++) begin
            cycle();
            busy_any = m_busy;
            for (int i = 0; i < N; i++) if (words_left[i] > 0) busy_any = 1'b1;
        end
        check_eq("drained", busy_any, 1'b0);
        for (int i = 0; i < N; i++) check_eq("rx_count", rx_seq[i], seq[i]);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Round-robin arbiter that shares the single write port of the FIFO buffer among N_REQ producers.
Each producer uses a valid/ready handshake. A granted producer holds the port for a burst of up to MAX_BURST words, and the port then rotates to the next producer.
Writes are back-pressured by the FIFO full flag, so the FIFO never sees a write while full.
The block sits directly in front of the FIFO's write/data_in/full interface.

Parameters:
WIDTH, 32, data word width; must match the FIFO's WIDTH.
N_REQ, 4, number of producers; must be >= 2.
MAX_BURST, 4, maximum words accepted from one producer per grant; must be >= 1.

Ports:
clk  input  1  single clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
req_valid  input  N_REQ  bit i set: producer i presents a word.
req_data  input  N_REQ*WIDTH  producer i's word is bits [i*WIDTH +: WIDTH].
req_ready  output  N_REQ  bit i set: producer i's word is accepted this cycle.
fifo_full  input  1  FIFO full flag.
fifo_write  output  1  FIFO write strobe.
fifo_data_in  output  WIDTH  word written to the FIFO.
grant_valid  output  1  a producer currently owns the port.
grant_id  output  $clog2(N_REQ)  index of the owning producer.

Behaviour:
- Reset (async assert, sync release) sets:
  - state=IDLE, grant_id=0, rr_ptr=0, burst_cnt=0.
  - fifo_write=0, req_ready=0, grant_valid=0, fifo_data_in=0.
  - Outputs drop immediately on assert, including mid-burst. A partially sent burst is abandoned; no word is written in that cycle.
- State register is IDLE or BURST. grant_valid = (state==BURST).
- Arbitration function (combinational):
  - Searches req_valid starting at rr_ptr and wrapping modulo N_REQ.
  - Returns the first set index, plus a found flag.
- IDLE:
  - If found: next state BURST, grant_id=found index, burst_cnt=0.
  - Otherwise stay in IDLE.
  - No transfer ever occurs in IDLE, so a new grant costs one cycle of latency.
- BURST:
  - xfer = req_valid[grant_id] && !fifo_full.
  - req_ready[grant_id] = !fifo_full. All other req_ready bits are 0.
  - fifo_write = xfer. fifo_data_in = req_data slice of grant_id (combinational, zero latency).
  - On xfer, burst_cnt increments.
- BURST exit condition: (xfer && burst_cnt==MAX_BURST-1) or !req_valid[grant_id].
- On exit:
  - rr_ptr <= (grant_id+1) mod N_REQ.
  - Arbitration is re-run in the same cycle using the updated pointer value on the current req_valid.
  - If found: stay in BURST with the new grant_id and burst_cnt=0 (back-to-back, no bubble).
  - Otherwise: go to IDLE.
- Producer rules:
  - Once req_valid[i] rises, it and its data hold until req_ready[i] is seen with valid.
  - Dropping valid without a transfer is a protocol violation; behaviour in that case is undefined.
- FIFO full:
  - While fifo_full=1 in BURST: no xfer, burst_cnt frozen, grant held indefinitely (no timeout).
  - Transfer resumes the first cycle fifo_full=0.
- Fairness: every producer with valid held is granted within N_REQ-1 other bursts.
- Requester at grant_id is lowest priority on re-arbitration. It is re-granted back-to-back only if no other valid is set.
- MAX_BURST=1 degenerates to per-word round-robin.
- burst_cnt is $clog2(MAX_BURST+1) bits wide and never exceeds MAX_BURST-1.
- Simultaneous fifo_full rise and burst end: no xfer, so no exit unless valid is low.

Test Plan:
1. Reset with all req_valid=1, release at cycle 0.
   - Cycle 1: grant_id=0, 4 writes of producer 0 data.
   - Then grants 1,2,3,0 each for 4 words, with no idle cycles between bursts.
2. Only producer 2 valid, 10 words, MAX_BURST=4.
   - Bursts 4,4,2 back-to-back on grant_id=2; fifo_write is high 10 consecutive cycles after the first grant.
   - Then IDLE, grant_valid=0.
3. Producer 1 bursting; fifo_full=1 for 5 cycles after its 2nd word.
   - fifo_write=0 and req_ready=0 for those 5 cycles, grant held, burst_cnt=2 frozen.
   - 3rd and 4th words are written after full drops.
4. Producers 0 and 3 valid, producer 0 stops after 1 word.
   - Exit on valid low, grant moves to 3 with no bubble.
   - rr_ptr=1, so 3 is found by the search.
5. Assert reset_n=0 mid-burst after the 2nd word.
   - fifo_write, req_ready and grant_valid go 0 the same cycle.
   - After release, arbitration restarts from producer 0.
6. Random valid/full traffic, 10k cycles.
   - Scoreboard: FIFO receives every accepted word exactly once, in per-producer order.
   - No fifo_write while fifo_full. No producer waits more than 3 bursts.
